// File: rtl/dcm_prog_serializer_if.sv
// dcm_prog_serializer_if: request handshake, DCM programming pins and status of the DCM serializer.
interface dcm_prog_serializer_if;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_multiplier;
   logic [7:0] req_divider;
   logic       dcm_prog_en;
   logic       dcm_prog_data;
   logic       dcm_prog_done;
   logic       done_pulse;
   logic       error;
   logic [7:0] current_multiplier;
   modport master (
      output req_valid, req_multiplier, req_divider, dcm_prog_done,
      input  req_ready, dcm_prog_en, dcm_prog_data, done_pulse, error, current_multiplier
   );
   modport slave (
      input  req_valid, req_multiplier, req_divider, dcm_prog_done,
      output req_ready, dcm_prog_en, dcm_prog_data, done_pulse, error, current_multiplier
   );
endinterface

// File: rtl/dcm_prog_serializer.sv
// dcm_prog_serializer: clamps an M/D request and shifts the DCM_CLKGEN LoadD/LoadM/GO sequence out.
// Define DCM_PROG_RETRY_EN to replay the sequence once after a PROGDONE timeout.
module dcm_prog_serializer #(
   parameter int          MAXIMUM_MULTIPLIER = 64,
   parameter int          MINIMUM_MULTIPLIER = 2,
   parameter logic [15:0] DONE_TIMEOUT       = 16'd1023
) (
   input logic                  clk,
   input logic                  reset,
   dcm_prog_serializer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_DONE} state_t;
   localparam logic [7:0] MAX_M = 8'(MAXIMUM_MULTIPLIER);
   localparam logic [7:0] MIN_M = 8'(MINIMUM_MULTIPLIER);
   state_t      state_q, state_d;
   logic [4:0]  step_q, step_d;
   logic [15:0] timer_q, timer_d, word_q, word_d;
   logic [7:0]  mc_q, mc_d, cur_q, cur_d, req_mc, req_dc;
   logic        ready_q, ready_d, en_q, en_d, data_q, data_d, done_q, done_d, err_q, err_d;
   logic        accept, skip, success, timeout, give_up;
   logic [3:0]  idx;
`ifdef DCM_PROG_RETRY_EN
   logic        retry_q, retry_d;
`endif
   always_comb begin
      req_mc  = bus.req_multiplier < MIN_M ? MIN_M : (bus.req_multiplier > MAX_M ? MAX_M : bus.req_multiplier);
      req_dc  = bus.req_divider == 8'd0 ? 8'd1 : bus.req_divider;
      accept  = bus.req_valid && ready_q;
      skip    = req_mc == cur_q && cur_q != 8'd0;
      success = state_q == WAIT_DONE && bus.dcm_prog_done;
      timeout = state_q == WAIT_DONE && !bus.dcm_prog_done && timer_q == DONE_TIMEOUT - 16'd1;
`ifdef DCM_PROG_RETRY_EN
      give_up = timeout && retry_q;
      retry_d = accept ? 1'b0 : (timeout ? 1'b1 : retry_q);
`else
      give_up = timeout;
`endif
      state_d = state_q;
      step_d  = step_q;
      timer_d = timer_q;
      mc_d    = accept ? req_mc : mc_q;
      word_d  = accept ? {req_mc - 8'd1, req_dc - 8'd1} : word_q;
      case (state_q)
         IDLE:
            if (accept && !skip) begin
               state_d = SHIFT;
               step_d  = 5'd0;
            end
         SHIFT:
            if (step_q == 5'd25) begin
               state_d = WAIT_DONE;
               timer_d = 16'd0;
            end else step_d = step_q + 5'd1;
         default: begin
            timer_d = timer_q + 16'd1;
            if (success || give_up) state_d = IDLE;
            else if (timeout) begin
               state_d = SHIFT;
               step_d  = 5'd0;
            end
         end
      endcase
      // LoadD payload sits on steps 2-9, LoadM payload on steps 15-22
      idx     = step_d[3:0] - (step_d < 5'd15 ? 4'd2 : 4'd7);
      en_d    = state_d == SHIFT && (step_d <= 5'd9 || (step_d >= 5'd13 && step_d <= 5'd22) || step_d == 5'd25);
      data_d  = state_d == SHIFT && (step_d == 5'd0 || step_d == 5'd13 || step_d == 5'd14 ||
                (((step_d >= 5'd2 && step_d <= 5'd9) || (step_d >= 5'd15 && step_d <= 5'd22)) && word_d[idx]));
      ready_d = state_d == IDLE && !(accept && skip);
      done_d  = (accept && skip) || success;
      err_d   = accept ? 1'b0 : (give_up ? 1'b1 : err_q);
      cur_d   = success ? mc_q : cur_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         step_q  <= 5'd0;
         timer_q <= 16'd0;
         word_q  <= 16'd0;
         mc_q    <= 8'd0;
         cur_q   <= 8'd0;
         ready_q <= 1'b1;
         en_q    <= 1'b0;
         data_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef DCM_PROG_RETRY_EN
         retry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         timer_q <= timer_d;
         word_q  <= word_d;
         mc_q    <= mc_d;
         cur_q   <= cur_d;
         ready_q <= ready_d;
         en_q    <= en_d;
         data_q  <= data_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef DCM_PROG_RETRY_EN
         retry_q <= retry_d;
`endif
      end
   end
   assign bus.req_ready          = ready_q;
   assign bus.dcm_prog_en        = en_q;
   assign bus.dcm_prog_data      = data_q;
   assign bus.done_pulse         = done_q;
   assign bus.error              = err_q;
   assign bus.current_multiplier = cur_q;
endmodule

// File: tb/tb_dcm_prog_serializer.sv
// tb_dcm_prog_serializer: directed vectors for the DCM serializer, DONE_TIMEOUT shortened to 20.
module tb_dcm_prog_serializer;
   typedef struct {
      logic [7:0] m, d, mm1, dm1, cur;
   } vec_t;
   localparam logic [25:0] EN_EXP = {1'b1, 2'b00, 10'h3FF, 3'b000, 10'h3FF};
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   passed = 0;
   vec_t vecs[4];
   dcm_prog_serializer_if bus();
   dcm_prog_serializer #(.DONE_TIMEOUT(16'd20)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic run_seq(input logic [7:0] m, input logic [7:0] d, input bit hold,
                          output logic [25:0] en_tr, output logic [25:0] data_tr, output logic rdy_any);
      bus.req_multiplier = m;
      bus.req_divider    = d;
      bus.req_valid      = 1'b1;
      tick();
      bus.req_valid = hold;
      rdy_any = 1'b0;
      for (int k = 0; k < 26; k++) begin
         en_tr[k]   = bus.dcm_prog_en;
         data_tr[k] = bus.dcm_prog_data;
         rdy_any    = rdy_any | bus.req_ready;
         if (hold) begin
            bus.req_multiplier = 8'($urandom);
            bus.req_divider    = 8'($urandom);
         end
         tick();
      end
      bus.req_valid = 1'b0;
   endtask
   task automatic chk_seq(input string name, input logic [25:0] en_tr, input logic [25:0] data_tr,
                          input logic [7:0] mm1, input logic [7:0] dm1);
      chk({name, " en"}, 32'(en_tr), 32'(EN_EXP));
      chk({name, " D-1"}, 32'(data_tr[9:2]), 32'(dm1));
      chk({name, " M-1"}, 32'(data_tr[22:15]), 32'(mm1));
      chk({name, " cmd"}, 32'({data_tr[0], data_tr[1], data_tr[13], data_tr[14], data_tr[25]}), 32'b10110);
      chk({name, " gaps"}, 32'({data_tr[10], data_tr[11], data_tr[12], data_tr[23], data_tr[24]}), 32'd0);
   endtask
   task automatic finish_ok(input string name, input logic [7:0] cur);
      logic busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         busy = busy | bus.dcm_prog_en | bus.dcm_prog_data | bus.done_pulse | bus.req_ready;
         tick();
      end
      chk({name, " wait quiet"}, 32'(busy), 32'd0);
      bus.dcm_prog_done = 1'b1;
      tick();
      bus.dcm_prog_done = 1'b0;
      chk({name, " done_pulse"}, 32'(bus.done_pulse), 32'd1);
      chk({name, " ready"}, 32'(bus.req_ready), 32'd1);
      chk({name, " cur"}, 32'(bus.current_multiplier), 32'(cur));
      tick();
      chk({name, " pulse width"}, 32'(bus.done_pulse), 32'd0);
   endtask
   initial begin
      logic [25:0] en_tr, data_tr;
      logic        rdy_any, done_seen;
      int          n, en_cnt;
      vecs[0] = '{m: 8'd16,  d: 8'd8, mm1: 8'd15, dm1: 8'd7, cur: 8'd16};
      vecs[1] = '{m: 8'd200, d: 8'd1, mm1: 8'd63, dm1: 8'd0, cur: 8'd64};
      vecs[2] = '{m: 8'd0,   d: 8'd0, mm1: 8'd1,  dm1: 8'd0, cur: 8'd2};
      vecs[3] = '{m: 8'd16,  d: 8'd3, mm1: 8'd15, dm1: 8'd2, cur: 8'd16};
      bus.req_valid = 1'b0;
      bus.req_multiplier = 8'd0;
      bus.req_divider = 8'd0;
      bus.dcm_prog_done = 1'b0;
      tick();
      tick();
      chk("reset outputs", 32'({bus.req_ready, bus.dcm_prog_en, bus.dcm_prog_data, bus.done_pulse, bus.error}), 32'b10000);
      chk("reset cur", 32'(bus.current_multiplier), 32'd0);
      reset = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         run_seq(vecs[i].m, vecs[i].d, 1'b0, en_tr, data_tr, rdy_any);
         chk($sformatf("vec%0d busy ready", i), 32'(rdy_any), 32'd0);
         chk_seq($sformatf("vec%0d", i), en_tr, data_tr, vecs[i].mm1, vecs[i].dm1);
         finish_ok($sformatf("vec%0d", i), vecs[i].cur);
      end
      // repeat of the multiplier already in place
      bus.req_multiplier = 8'd16;
      bus.req_divider = 8'd77;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      chk("skip T+1", 32'({bus.done_pulse, bus.req_ready, bus.dcm_prog_en}), 32'b100);
      tick();
      chk("skip T+2", 32'({bus.done_pulse, bus.req_ready, bus.dcm_prog_en}), 32'b010);
      // no PROGDONE: timeout (and replay when retry is built in)
      run_seq(8'd9, 8'd2, 1'b0, en_tr, data_tr, rdy_any);
      chk_seq("tmo", en_tr, data_tr, 8'd8, 8'd1);
      n = 0;
      en_cnt = 0;
      done_seen = 1'b0;
      while (!bus.error && n < 200) begin
         en_cnt += int'(bus.dcm_prog_en);
         done_seen = done_seen | bus.done_pulse;
         tick();
         n++;
      end
`ifdef DCM_PROG_RETRY_EN
      chk("tmo latency", 32'(n), 32'd66);
      chk("tmo replay en", 32'(en_cnt), 32'd21);
`else
      chk("tmo latency", 32'(n), 32'd20);
      chk("tmo replay en", 32'(en_cnt), 32'd0);
`endif
      chk("tmo no pulse", 32'(done_seen), 32'd0);
      chk("tmo state", 32'({bus.error, bus.req_ready, bus.done_pulse}), 32'b110);
      chk("tmo cur", 32'(bus.current_multiplier), 32'd16);
      tick();
      chk("tmo sticky", 32'(bus.error), 32'd1);
      bus.req_multiplier = 8'd9;
      bus.req_divider = 8'd2;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      chk("err cleared", 32'(bus.error), 32'd0);
      for (int k = 0; k < 26; k++) tick();
      finish_ok("after tmo", 8'd9);
      // reset during step 12
      bus.req_multiplier = 8'd30;
      bus.req_divider = 8'd4;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      for (int k = 0; k < 12; k++) tick();
      chk("step12 en", 32'(bus.dcm_prog_en), 32'd0);
      tick();
      chk("step13 en", 32'({bus.dcm_prog_en, bus.dcm_prog_data}), 32'b11);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort outputs", 32'({bus.dcm_prog_en, bus.dcm_prog_data, bus.req_ready, bus.done_pulse}), 32'b0010);
      chk("abort cur", 32'(bus.current_multiplier), 32'd0);
      bus.dcm_prog_done = 1'b1;
      tick();
      bus.dcm_prog_done = 1'b0;
      tick();
      chk("stray done", 32'({bus.done_pulse, bus.req_ready, bus.error}), 32'b010);
      chk("stray cur", 32'(bus.current_multiplier), 32'd0);
      // req_valid held with changing data while busy
      run_seq(8'd20, 8'd6, 1'b1, en_tr, data_tr, rdy_any);
      chk("hold ready", 32'(rdy_any), 32'd0);
      chk_seq("hold", en_tr, data_tr, 8'd19, 8'd5);
      finish_ok("hold", 8'd20);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/dcm_prog_serializer.md
Name: dcm_prog_serializer

Overview:
- Downstream stage of the dynamic DCM clock controller.
- Takes one requested multiplier/divider pair per handshake, clamps it, and serialises the DCM_CLKGEN dynamic-reprogramming sequence onto PROGEN/PROGDATA: LoadD, LoadM, then GO.
- Waits for PROGDONE with a timeout and reports completion or failure back to the controller.
- Runs on the same clock that drives the DCM PROGCLK pin.

Parameters:
- MAXIMUM_MULTIPLIER, 64: upper clamp for the multiplier M.
- MINIMUM_MULTIPLIER, 2: lower clamp for M.
- DONE_TIMEOUT, 1023: cycles to wait for prog_done after GO before flagging an error; width 16 bits.

Ports:
- clk  in  1  system clock, also the DCM PROGCLK.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_multiplier  in  8  requested M (not M-1).
- req_divider  in  8  requested D (not D-1); values 0 and 1 are treated as 1.
- dcm_prog_en  out  1  DCM PROGEN.
- dcm_prog_data  out  1  DCM PROGDATA.
- dcm_prog_done  in  1  DCM PROGDONE.
- done_pulse  out  1  one-cycle pulse when a request completes successfully.
- error  out  1  sticky timeout flag; cleared by reset or by the next accepted request.
- current_multiplier  out  8  last successfully programmed M, after clamping.

Behaviour:
- Reset state: IDLE.
- Reset values: req_ready=1, dcm_prog_en=0, dcm_prog_data=0, done_pulse=0, error=0, current_multiplier=0, internal counters=0.
- Reset mid-sequence aborts immediately. The outputs above apply on the next edge and no done_pulse is produced.

Accept (cycle T, req_valid && req_ready):
- Latch Mc = clamp(req_multiplier, MINIMUM_MULTIPLIER, MAXIMUM_MULTIPLIER).
- Latch Dc = max(req_divider, 1).
- Build shift word {Mc-1, Dc-1}, 16 bits.
- Clear error. req_ready drops at T+1.

Skip path:
- If Mc == current_multiplier and current_multiplier != 0, no DCM traffic is generated.
- done_pulse=1 at T+1; req_ready=1 at T+2.

Sequence: all outputs are registered, and step k is driven during cycle T+1+k. {en,data} per step:
- Steps 0,1: 11, 10 (LoadD command).
- Steps 2-9: en=1, data = shift word bit 0..7, LSB first (D-1).
- Steps 10-12: 00.
- Steps 13,14: 11, 11 (LoadM command).
- Steps 15-22: en=1, data = bits 8..15, LSB first (M-1).
- Steps 23,24: 00.
- Step 25: 10 (GO).
- Step 26 onward: WAIT_DONE, outputs 00.

State machine:
- States: IDLE -> SHIFT (steps 0-25, 5-bit step counter) -> WAIT_DONE -> IDLE.

WAIT_DONE:
- Timer starts at 0 on entry and increments each cycle.
- prog_done seen high on a cycle: current_multiplier<=Mc, done_pulse=1 on the next cycle, then return to IDLE.
- Timer reaches DONE_TIMEOUT with no prog_done: error<=1, current_multiplier unchanged, return to IDLE, no done_pulse.
- prog_done and timeout on the same cycle: success wins.

Other rules:
- prog_done outside WAIT_DONE is ignored.
- req_valid while busy is ignored; the requester must hold it.
- Latched values are immune to input changes after accept.
- All subtractions are 8-bit. Clamping guarantees M-1 >= 1 and D-1 >= 0, so there is no wrap.

Optional Feature:
- Macro: DCM_PROG_RETRY_EN.
- Defined: on timeout, replay the full sequence from step 0 once with the same latched word. error is set only if the retry also times out. A second timeout register counts attempts.
- Undefined: the first timeout sets error and returns to IDLE.

Test Plan:
- Request M=16, D=8 after reset: PROGDATA on steps 2-9 = 1,1,1,0,0,0,0,0 (D-1=7). Steps 15-22 = 1,1,1,1,0,0,0,0 (M-1=15). GO at step 25. prog_done pulsed 5 cycles later -> done_pulse one cycle later, current_multiplier=16, req_ready=1.
- Request M=200, then M=0 -> programs M-1=63, then M-1=1. current_multiplier = 64, then 2.
- Repeat M=16 after a successful 16 -> no PROGEN activity, done_pulse at T+1.
- No prog_done with DONE_TIMEOUT=20 -> error=1 at GO+20, no done_pulse, current_multiplier unchanged. The next request clears error. With DCM_PROG_RETRY_EN, the sequence replays once before error is set.
- Assert reset at step 12 -> PROGEN=0 and req_ready=1 next cycle. A later prog_done is ignored.
- req_valid held with changing data during SHIFT -> latched word is unchanged and no second accept occurs until IDLE.
